// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM states, owner codes and default widths.
package ram_port_arbiter_pkg;

    localparam int unsigned DefAw = 8;
    localparam int unsigned DefDw = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StAcc  = 2'b01,
        StResp = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OwnNone = 2'b00,
        OwnCpu  = 2'b01,
        OwnHost = 2'b10
    } owner_e;

endpackage

// File: rtl/ram_port_arbiter_arb_rr2.sv
// Two-way round-robin picker: bit 0 is the CPU, bit 1 the host; a tie goes to whoever
// did not win last time.
module ram_port_arbiter_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_host,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_host ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port program/data RAM between the CPU and the host loader port.
// One access takes ACC (strobes) then RESP (ack + read data), re-arbitrating in RESP.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned AW = DefAw,
    parameter int unsigned DW = DefDw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_ack,
    input  logic          host_lock,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_rden,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,
    output logic [1:0]    owner
);

    state_e        state_q, state_d;
    owner_e        owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          last_host_q;
    logic [DW-1:0] cpu_rdata_q, host_rdata_q;

    logic       arb_en;
    logic       elig_cpu, elig_host;
    logic [1:0] gnt;
    logic       grant;

    // The requester being acked in RESP still shows its old req level, so it sits out.
    assign arb_en    = (state_q == StIdle) || (state_q == StResp);
    assign elig_cpu  = cpu_req & ~host_lock & ~((state_q == StResp) && (owner_q == OwnCpu));
    assign elig_host = host_req & ~((state_q == StResp) && (owner_q == OwnHost));

    ram_port_arbiter_arb_rr2 u_arb (
        .req       ({elig_host & arb_en, elig_cpu & arb_en}),
        .last_host (last_host_q),
        .gnt       (gnt)
    );

    assign grant = |gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StAcc;
            StAcc:   state_d = StResp;
            StResp:  state_d = grant ? StAcc : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes and acks decode straight from state so an async reset drops them at once.
    always_comb begin
        ram_addr   = '0;
        ram_data   = '0;
        ram_rden   = 1'b0;
        ram_wren   = 1'b0;
        cpu_ack    = 1'b0;
        host_ack   = 1'b0;
        owner      = OwnNone;
        cpu_rdata  = cpu_rdata_q;
        host_rdata = host_rdata_q;
        unique case (state_q)
            StAcc: begin
                ram_addr = addr_q;
                ram_data = wdata_q;
                ram_rden = ~we_q;
                ram_wren = we_q;
                owner    = owner_q;
            end
            StResp: begin
                owner = owner_q;
                if (owner_q == OwnCpu) begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = ram_q;
                end
                if (owner_q == OwnHost) begin
                    host_ack   = 1'b1;
                    host_rdata = ram_q;
                end
            end
            default: ;
        endcase
    end

    assign cpu_stall = (cpu_req & ~cpu_ack) | host_lock;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OwnNone;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_host_q  <= 1'b1;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            if (state_q == StResp) begin
                if (owner_q == OwnCpu)  cpu_rdata_q  <= ram_q;
                if (owner_q == OwnHost) host_rdata_q <= ram_q;
            end
            if (grant) begin
                owner_q     <= gnt[1] ? OwnHost : OwnCpu;
                last_host_q <= gnt[1];
                we_q        <= gnt[1] ? host_we : cpu_we;
                addr_q      <= gnt[1] ? host_addr : cpu_addr;
                wdata_q     <= gnt[1] ? host_wdata : cpu_wdata;
            end else if (state_q == StResp) begin
                owner_q <= OwnNone;
            end
        end
    end

endmodule
